// File: rtl/wire_pkg.sv
// Shared definitions for the wire-cut encoder and any logic that interprets its outputs.
package wire_pkg;

  typedef logic [2:0] wire_idx_t;

  localparam int unsigned N_WIRES_DEFAULT = 6;
  localparam int unsigned MAX_WIRES       = 7;
  localparam wire_idx_t   NO_WIRE         = 3'b111;

  // Index of the lowest set bit, or NO_WIRE when the mask is empty.
  function automatic wire_idx_t lowest_set(input logic [MAX_WIRES-1:0] mask);
    wire_idx_t idx;
    idx = NO_WIRE;
    for (int i = MAX_WIRES - 1; i >= 0; i--) begin
      if (mask[i]) idx = wire_idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/wire_debouncer.sv
// One wire: two-flop synchronizer, consecutive-mismatch counter, stable level and a
// registered one-cycle pulse on every accepted 1->0 transition.
module wire_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_fall
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic            r_sync1;
  logic            r_sync2;
  logic            r_level;
  logic            r_fall;
  logic [CntW-1:0] r_cnt;

  logic            w_level_d;
  logic            w_fall_d;
  logic [CntW-1:0] w_cnt_d;

  // The level flips on the cycle that completes the run of mismatches.
  always_comb begin
    w_level_d = r_level;
    w_fall_d  = 1'b0;
    w_cnt_d   = r_cnt;
    if (r_sync2 == r_level) begin
      w_cnt_d = '0;
    end else if (r_cnt == CntMax) begin
      w_cnt_d   = '0;
      w_level_d = r_sync2;
      w_fall_d  = r_level;
    end else begin
      w_cnt_d = r_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b1;
      r_fall  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      r_level <= w_level_d;
      r_fall  <= w_fall_d;
      r_cnt   <= w_cnt_d;
    end
  end

  assign o_fall = r_fall;

endmodule

// File: rtl/wire_cut_encoder.sv
// Debounces each wire, queues cut events and reports them one per cycle, lowest index first,
// while keeping a sticky mask and count of every wire already reported.
module wire_cut_encoder
  import wire_pkg::*;
#(
  parameter int unsigned N_WIRES         = N_WIRES_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [N_WIRES-1:0] wires_raw,
  output logic [2:0]         wire_to_cut,
  output logic               cut_valid,
  output logic [N_WIRES-1:0] cut_mask,
  output logic [2:0]         cut_count,
  output logic               all_cut
);

  localparam logic [2:0] CountMax = 3'(N_WIRES);

  logic [N_WIRES-1:0] w_fall;
  logic [N_WIRES-1:0] r_pending;
  logic [N_WIRES-1:0] r_mask;
  logic [2:0]         r_count;
  wire_idx_t          r_last;
  logic               r_all_cut;

  wire_idx_t          w_idx;
  logic               w_any;
  logic [N_WIRES-1:0] w_grant;
  logic [N_WIRES-1:0] w_pending_d;
  logic [N_WIRES-1:0] w_mask_d;
  logic [2:0]         w_count_d;

  for (genvar g = 0; g < N_WIRES; g++) begin : g_deb
    wire_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .i_clk  (CLK),
      .i_rst_n(RST_N),
      .i_raw  (wires_raw[g]),
      .o_fall (w_fall[g])
    );
  end

  always_comb begin
    w_any   = |r_pending;
    w_idx   = lowest_set(MAX_WIRES'(r_pending));
    w_grant = '0;
    if (w_any) w_grant = N_WIRES'(1) << w_idx;
    // A wire already reported never re-enters the queue, even after a reconnect.
    w_pending_d = (r_pending | (w_fall & ~r_mask)) & ~w_grant;
    w_mask_d    = r_mask | w_grant;
    w_count_d   = r_count;
    if (w_any && (r_count != CountMax)) w_count_d = r_count + 3'd1;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_pending <= '0;
      r_mask    <= '0;
      r_count   <= '0;
      r_last    <= NO_WIRE;
      r_all_cut <= 1'b0;
    end else begin
      r_pending <= w_pending_d;
      r_mask    <= w_mask_d;
      r_count   <= w_count_d;
      if (w_any) r_last <= w_idx;
      r_all_cut <= r_all_cut | (w_count_d == CountMax);
    end
  end

  assign cut_valid   = w_any;
  assign wire_to_cut = w_any ? w_idx : r_last;
  assign cut_mask    = r_mask;
  assign cut_count   = r_count;
  assign all_cut     = r_all_cut;

endmodule

// File: tb/tb_wire_cut_encoder.sv
// Self-checking bench for wire_cut_encoder with N_WIRES = 6, DEBOUNCE_CYCLES = 4.
module tb_wire_cut_encoder;

  localparam int NW = 6;
  localparam int DB = 4;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic [NW-1:0] wires_raw;
  logic [2:0]    wire_to_cut;
  logic          cut_valid;
  logic [NW-1:0] cut_mask;
  logic [2:0]    cut_count;
  logic          all_cut;

  always #5 CLK = ~CLK;

  wire_cut_encoder #(
    .N_WIRES        (NW),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .wires_raw  (wires_raw),
    .wire_to_cut(wire_to_cut),
    .cut_valid  (cut_valid),
    .cut_mask   (cut_mask),
    .cut_count  (cut_count),
    .all_cut    (all_cut)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a wire is cut once D consecutive low samples have been taken since
  // reset; its report becomes eligible 3 edges after the D-th sample.
  int            edge_no;
  int            run      [NW];
  int            due      [NW];
  bit            detected [NW];
  logic [NW-1:0] m_pend;
  logic [NW-1:0] m_mask;
  int            m_count;
  logic [2:0]    m_last;
  int            pulses;

  typedef struct {
    logic          rst_n;
    logic [NW-1:0] raw;
    int            cycles;
    int            pulses;
    logic [NW-1:0] mask;
    logic [2:0]    count;
    logic [2:0]    wtc;
    logic          all;
  } vec_t;

  vec_t tbl[11];

  function automatic int lowest(input logic [NW-1:0] v);
    for (int i = 0; i < NW; i++) if (v[i]) return i;
    return 7;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend  = '0;
    m_mask  = '0;
    m_count = 0;
    m_last  = 3'b111;
    for (int w = 0; w < NW; w++) begin
      run[w]      = 0;
      due[w]      = -1;
      detected[w] = 1'b0;
    end
  endtask

  task automatic model_edge();
    int i;
    edge_no++;
    if (!RST_N) begin
      model_reset();
    end else begin
      if (m_pend != '0) begin
        i = lowest(m_pend);
        m_pend[i] = 1'b0;
        m_mask[i] = 1'b1;
        if (m_count < NW) m_count++;
        m_last = 3'(i);
      end
      for (int w = 0; w < NW; w++) begin
        if (due[w] == edge_no) begin
          if (!m_mask[w]) m_pend[w] = 1'b1;
          due[w] = -1;
        end
      end
      for (int w = 0; w < NW; w++) begin
        if (wires_raw[w] == 1'b0) run[w]++;
        else run[w] = 0;
        if (run[w] == DB && !detected[w]) begin
          detected[w] = 1'b1;
          due[w]      = edge_no + 3;
        end
      end
    end
  endtask

  task automatic tick();
    int exp_wtc;
    @(posedge CLK);
    model_edge();
    #2;
    exp_wtc = (m_pend != '0) ? lowest(m_pend) : int'(m_last);
    chk("model valid", 32'(cut_valid), 32'(m_pend != '0));
    chk("model wire_to_cut", 32'(wire_to_cut), 32'(exp_wtc));
    chk("model cut_mask", 32'(cut_mask), 32'(m_mask));
    chk("model cut_count", 32'(cut_count), 32'(m_count));
    chk("model all_cut", 32'(all_cut), 32'(m_count == NW));
    if (cut_valid === 1'b1) pulses++;
  endtask

  initial begin
    edge_no   = 0;
    pulses    = 0;
    model_reset();
    RST_N     = 1'b0;
    wires_raw = '1;

    //           rst   raw    cyc pls mask   cnt   wtc   all
    tbl[0]  = '{1'b0, 6'h3F, 3,  0,  6'h00, 3'd0, 3'd7, 1'b0};  // reset
    tbl[1]  = '{1'b1, 6'h3B, 3,  0,  6'h00, 3'd0, 3'd7, 1'b0};  // wire 2 glitch
    tbl[2]  = '{1'b1, 6'h3F, 10, 0,  6'h00, 3'd0, 3'd7, 1'b0};
    tbl[3]  = '{1'b1, 6'h1F, 10, 1,  6'h20, 3'd1, 3'd5, 1'b0};  // wire 5 cut
    tbl[4]  = '{1'b1, 6'h05, 12, 3,  6'h3A, 3'd4, 3'd4, 1'b0};  // 4,1,3 together
    tbl[5]  = '{1'b1, 6'h04, 10, 1,  6'h3B, 3'd5, 3'd0, 1'b0};  // wire 0 cut
    tbl[6]  = '{1'b1, 6'h05, 10, 0,  6'h3B, 3'd5, 3'd0, 1'b0};  // wire 0 reconnect
    tbl[7]  = '{1'b1, 6'h04, 10, 0,  6'h3B, 3'd5, 3'd0, 1'b0};  // wire 0 cut again
    tbl[8]  = '{1'b1, 6'h00, 10, 1,  6'h3F, 3'd6, 3'd2, 1'b1};  // last wire
    tbl[9]  = '{1'b1, 6'h3F, 10, 0,  6'h3F, 3'd6, 3'd2, 1'b1};  // all reconnect
    tbl[10] = '{1'b0, 6'h3F, 3,  0,  6'h00, 3'd0, 3'd7, 1'b0};  // reset

    for (int r = 0; r < 11; r++) begin
      RST_N     = tbl[r].rst_n;
      wires_raw = tbl[r].raw;
      pulses    = 0;
      repeat (tbl[r].cycles) tick();
      chk($sformatf("row%0d pulses", r), 32'(pulses), 32'(tbl[r].pulses));
      chk($sformatf("row%0d wire_to_cut", r), 32'(wire_to_cut), 32'(tbl[r].wtc));
      chk($sformatf("row%0d cut_mask", r), 32'(cut_mask), 32'(tbl[r].mask));
      chk($sformatf("row%0d cut_count", r), 32'(cut_count), 32'(tbl[r].count));
      chk($sformatf("row%0d all_cut", r), 32'(all_cut), 32'(tbl[r].all));
    end

    // Exact latency of an isolated cut.
    RST_N = 1'b1;
    repeat (2) tick();
    wires_raw = 6'h1F;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("lat k%0d valid", k), 32'(cut_valid), 32'(k == 7));
      if (k == 7) chk("lat wire_to_cut", 32'(wire_to_cut), 32'd5);
    end
    chk("lat cut_mask", 32'(cut_mask), 32'h20);
    chk("lat cut_count", 32'(cut_count), 32'd1);

    // Simultaneous cuts come out in ascending order on consecutive cycles.
    wires_raw = 6'h05;
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk($sformatf("sim k%0d valid", k), 32'(cut_valid), 32'(k >= 7));
      if (k == 7) chk("sim first", 32'(wire_to_cut), 32'd1);
      if (k == 8) chk("sim second", 32'(wire_to_cut), 32'd3);
      if (k == 9) chk("sim third", 32'(wire_to_cut), 32'd4);
    end
    tick();
    chk("sim cut_count", 32'(cut_count), 32'd4);
    chk("sim hold wire_to_cut", 32'(wire_to_cut), 32'd4);

    // Staggered final cuts; all_cut follows the last pulse by one cycle.
    wires_raw = 6'h04;
    repeat (3) tick();
    wires_raw = 6'h00;
    repeat (6) tick();
    tick();
    chk("final valid", 32'(cut_valid), 32'd1);
    chk("final wire_to_cut", 32'(wire_to_cut), 32'd2);
    chk("final all_cut early", 32'(all_cut), 32'd0);
    tick();
    chk("final all_cut", 32'(all_cut), 32'd1);
    chk("final cut_count", 32'(cut_count), 32'd6);

    // Reset while reports are queued; held-low wires are re-reported afterwards.
    RST_N     = 1'b0;
    wires_raw = '1;
    repeat (2) tick();
    RST_N = 1'b1;
    repeat (2) tick();
    wires_raw = 6'h1A;
    repeat (7) tick();
    chk("rst pre valid", 32'(cut_valid), 32'd1);
    chk("rst pre wire_to_cut", 32'(wire_to_cut), 32'd0);
    RST_N = 1'b0;
    tick();
    chk("rst valid", 32'(cut_valid), 32'd0);
    chk("rst wire_to_cut", 32'(wire_to_cut), 32'd7);
    chk("rst cut_mask", 32'(cut_mask), 32'd0);
    chk("rst cut_count", 32'(cut_count), 32'd0);
    tick();
    RST_N = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk($sformatf("rerep k%0d valid", k), 32'(cut_valid), 32'(k >= 7));
      if (k == 7) chk("rerep first", 32'(wire_to_cut), 32'd0);
      if (k == 8) chk("rerep second", 32'(wire_to_cut), 32'd2);
      if (k == 9) chk("rerep third", 32'(wire_to_cut), 32'd5);
    end
    tick();
    chk("rerep cut_count", 32'(cut_count), 32'd3);
    chk("rerep cut_mask", 32'(cut_mask), 32'h25);

    // Random segments of held patterns, with glitches and occasional resets.
    RST_N     = 1'b0;
    wires_raw = '1;
    repeat (2) tick();
    RST_N = 1'b1;
    for (int seg = 0; seg < 160; seg++) begin
      int            len;
      logic [NW-1:0] flip;
      if ($urandom_range(0, 11) == 0) begin
        RST_N     = 1'b0;
        wires_raw = NW'($urandom) | NW'($urandom);
        repeat ($urandom_range(1, 3)) tick();
        RST_N = 1'b1;
      end
      len       = $urandom_range(1, 8);
      flip      = NW'($urandom) & NW'($urandom);
      wires_raw = wires_raw ^ flip;
      repeat (len) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
